am_demod_sequencer: RTL
=======================

# am_demod_sequencer

Time-multiplexed AM envelope engine: accepts one signed I/Q pair through a valid/ready handshake and computes floor(sqrt(I² + Q²)). It uses a single shared 12×12 signed multiplier over two cycles and a radix-4 digit-by-digit square root over 12 cycles. It sits between the CIC/decimator I/Q output and the audio path, replacing the fully pipelined two-multiplier demodulator where sample rate is low and multiplier count matters.

## Interface
- DATA_W, 12: signed I/Q width; root width equals DATA_W.
- SUM_W, 2*DATA_W: unsigned sum-of-squares width (24).
- ITERS, DATA_W: square-root iterations, one result bit each.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  I/Q pair present.
- in_ready  out  1  block can accept a pair; high only in IDLE.
- I_in  in  DATA_W  signed in-phase sample.
- Q_in  in  DATA_W  signed quadrature sample.
- out_valid  out  1  d_out holds a result.
- out_ready  in  1  downstream accepts d_out.
- d_out  out  DATA_W  unsigned magnitude, floor(sqrt(I²+Q²)).
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, MUL_I, MUL_Q, SQRT, DONE.
- IDLE: in_ready=1. On in_valid, register I_in/Q_in into op_i/op_q and go to MUL_I.
- MUL_I: multiplier operands are op_i,op_i. acc <= op_i*op_i, zero-extended to SUM_W. Go to MUL_Q.
- MUL_Q: multiplier operands are op_q,op_q. acc <= acc + op_q*op_q. Clear root, remainder, and iteration counter. Go to SQRT.
- SQRT: one radix-4 non-restoring step per cycle:
  - Shift the top 2 bits of acc into the remainder, then shift acc left 2.
  - Trial value is {root,r_sign,1}.
  - Add the trial when the remainder is negative, else subtract it.
  - Shift !r_sign into root.
  - After ITERS steps, load d_out <= root, set out_valid=1, go to DONE.
- DONE: hold d_out and out_valid stable. On out_ready, clear out_valid and go to IDLE.
- Arithmetic widths:
  - Product is signed 2*DATA_W and always ≥0.
  - Max sum is 2·2048² = 2^23, which fits SUM_W unsigned without overflow.
  - Remainder is DATA_W+2 bits (14), signed.
  - Max root is 2896.
- The multiplier is the only multiplier instance and is used exactly twice per sample.
- Boundary cases:
  - in_valid while not IDLE: ignored, no capture.
  - I=Q=0 → 0.
  - I=-2048 is legal; its square is 4194304.
  - rst in any state: return to IDLE and discard the in-flight sample.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, d_out=0, busy=0, all internal registers 0.
- Accept edge E0 (in_valid & in_ready). MUL_I runs in the cycle after E0 and MUL_Q in the next. SQRT spans 12 cycles.
- out_valid rises after edge E0+15; that is the latency.
- With out_ready tied high, out_valid is a 1-cycle pulse. in_ready is high again the following cycle.
- Minimum accept-to-accept interval is 17 cycles.
- in_ready is combinational from state only, with no dependence on in_valid.
- out_ready low holds DONE indefinitely, with d_out stable.
- Simultaneous rst and out_ready: rst wins.

## Structure
- Package am_demod_pkg holds:
  - the state enum;
  - DATA_W, SUM_W and ITERS defaults;
  - the remainder-width constant (DATA_W+2).
- Sub-module am_isqrt_step, purely combinational: one radix-4 step, (acc, rem, root) → (acc', rem', root'). It is instantiated once and registered by the FSM, so it can be reused for a later unrolled variant.
- The multiplier is an inline single `*` with an operand mux selected by state, so it maps to one DSP block.

## Test plan
- I=3, Q=4, out_ready=1 → d_out=5, out_valid exactly 15 cycles after accept, in_ready low meanwhile.
- I=-2048, Q=-2048 → d_out=2896 (sum 8388608, no overflow). I=0, Q=0 → d_out=0.
- I=100, Q=-1 → 100; I=-1, Q=1 → 1 (floor behaviour).
- Hold out_ready=0 for 20 cycles after out_valid → d_out and out_valid stable, in_valid pulses ignored, in_ready=0. Release → accepted next sample computes correctly.
- Assert rst for one cycle during SQRT (iteration 5) → next cycle IDLE, out_valid=0, d_out=0. The following sample (5,12) → 13.
- in_valid held high continuously with 50 random pairs → each result equals the floor(sqrt) model, accept spacing is 17 cycles, no sample is lost or duplicated.

Source files
------------

// File: rtl/am_demod_pkg.sv
// Shared types and default widths for the time-multiplexed AM envelope engine.
package am_demod_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_SUM_W  = 2 * DEF_DATA_W;
    localparam int DEF_ITERS  = DEF_DATA_W;
    localparam int DEF_REM_W  = DEF_DATA_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_I = 3'd1,
        ST_MUL_Q = 3'd2,
        ST_SQRT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/am_isqrt_step.sv
// One radix-4 non-restoring square-root step: consumes two radicand bits, yields one root bit.
module am_isqrt_step
    import am_demod_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic [2*W-1:0] acc,
    input  logic [W+1:0]   rem,
    input  logic [W-1:0]   root,
    output logic [2*W-1:0] acc_nxt,
    output logic [W+1:0]   rem_nxt,
    output logic [W-1:0]   root_nxt
);

    logic [W+1:0] rem_sh;
    logic [W+1:0] trial;
    logic [W+1:0] rem_sum;

    // Remainder is two's complement in W+2 bits; wrap-around is harmless since the true value fits.
    assign rem_sh = {rem[W-1:0], acc[2*W-1:2*W-2]};
    assign trial  = {root, rem[W+1], 1'b1};

    always_comb begin
        rem_sum = rem_sh - trial;
        if (rem[W+1])
            rem_sum = rem_sh + trial;
    end

    assign acc_nxt  = {acc[2*W-3:0], 2'b00};
    assign rem_nxt  = rem_sum;
    assign root_nxt = {root[W-2:0], ~rem_sum[W+1]};

endmodule

// File: rtl/am_demod_sequencer.sv
// AM envelope: floor(sqrt(I^2 + Q^2)) using one shared multiplier over two cycles
// and a bit-serial radix-4 square root.
module am_demod_sequencer
    import am_demod_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = 2 * DATA_W,
    parameter int ITERS  = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] I_in,
    input  logic [DATA_W-1:0] Q_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] d_out,
    output logic              busy
);

    localparam int REM_W = DATA_W + 2;
    localparam int CNT_W = $clog2(ITERS + 1);

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] op_i, op_q, mul_a;
    logic signed [SUM_W-1:0]  mul_ext, prod;
    logic [SUM_W-1:0]         acc, acc_step;
    logic [REM_W-1:0]         rem, rem_step;
    logic [DATA_W-1:0]        root, root_step;
    logic [CNT_W-1:0]         cnt;
    logic                     sqrt_done;

    assign sqrt_done = (cnt == CNT_W'(ITERS));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_MUL_I;
            ST_MUL_I: state_nxt = ST_MUL_Q;
            ST_MUL_Q: state_nxt = ST_SQRT;
            ST_SQRT:  if (sqrt_done) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        mul_a    = (state == ST_MUL_Q) ? op_q : op_i;
    end

    // Single multiplier; operands sign-extended so the full-width square lands in the low SUM_W bits.
    assign mul_ext = {{(SUM_W - DATA_W){mul_a[DATA_W-1]}}, mul_a};
    assign prod    = mul_ext * mul_ext;

    am_isqrt_step #(.W(DATA_W)) u_step (
        .acc      (acc),
        .rem      (rem),
        .root     (root),
        .acc_nxt  (acc_step),
        .rem_nxt  (rem_step),
        .root_nxt (root_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_i      <= '0;
            op_q      <= '0;
            acc       <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            d_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_i <= I_in;
                        op_q <= Q_in;
                    end
                end
                ST_MUL_I: acc <= $unsigned(prod);
                ST_MUL_Q: begin
                    acc  <= acc + $unsigned(prod);
                    rem  <= '0;
                    root <= '0;
                    cnt  <= '0;
                end
                ST_SQRT: begin
                    if (sqrt_done) begin
                        d_out     <= root;
                        out_valid <= 1'b1;
                    end else begin
                        acc  <= acc_step;
                        rem  <= rem_step;
                        root <= root_step;
                        cnt  <= cnt + 1'b1;
                    end
                end
                ST_DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
